fb_mem_arbiter: RTL and testbench
=================================

Name: fb_mem_arbiter

Overview:
- Shares the single SDRAM controller command/data port between two framebuffer clients: LCD scanout (burst reads) and the Julia renderer (burst writes).
- Grants one client per fixed-length burst, sequences command then data beats, and forwards data between the granted client and the controller.
- Sits between the renderer/scanout FIFOs and the SDRAM controller that drives the S_* pins.

Parameters:
ADDR_W, 22, word address width of the SDRAM controller command port
DATA_W, 32, data width; matches the 32-bit SDRAM bus
BURST, 8, words per transaction, power of two, 2..256
MAX_WAIT, 64, cycles the renderer may wait while requesting before it overrides display urgency

Ports:
PLD_CLOCKINPUT  in  1  system clock; all logic on its rising edge
RST  in  1  synchronous, active-high reset
d_req  in  1  display requests one read burst
d_urgent  in  1  display FIFO below low-water mark
d_addr  in  ADDR_W  display burst start address; sampled at grant
d_gnt  out  1  display owns the port, from grant through the last beat
d_rvalid  out  1  read word valid for display
d_rdata  out  DATA_W  read word
r_req  in  1  renderer requests one write burst
r_addr  in  ADDR_W  renderer burst start address; sampled at grant
r_wdata  in  DATA_W  current write word (FIFO head)
r_wready  out  1  renderer FIFO pop; word consumed this cycle
r_gnt  out  1  renderer owns the port
m_cmd_valid  out  1  command to controller
m_cmd_ready  in  1  controller accepts command
m_cmd_we  out  1  1 = write burst, 0 = read burst
m_cmd_addr  out  ADDR_W  burst start address
m_wdata  out  DATA_W  write word to controller
m_wready  in  1  controller takes m_wdata this cycle
m_rvalid  in  1  controller read word valid
m_rdata  in  DATA_W  controller read word

Behaviour:
- Reset: state IDLE; d_gnt, r_gnt, m_cmd_valid, m_cmd_we, d_rvalid, r_wready = 0; m_cmd_addr = 0; beat counter, wait counter = 0; last_owner = renderer, so display wins the first tie.
- FSM states: IDLE, CMD, DATA.
- IDLE arbitration, evaluated every cycle, in priority order:
  (1) r_req and wait_cnt == MAX_WAIT -> renderer;
  (2) d_req and d_urgent -> display;
  (3) both requesting -> round-robin against last_owner;
  (4) the single requester wins.
- On a grant: latch the address and direction, assert the owner's gnt, go to CMD on the next cycle.
- CMD: m_cmd_valid = 1 with stable addr/we until m_cmd_ready; the accept cycle moves to DATA with beat = 0.
- DATA write: m_wdata = r_wdata combinationally; r_wready = m_wready.
- DATA read: d_rvalid = m_rvalid; d_rdata = m_rdata.
- Each handshaked beat increments beat. The beat at count BURST-1 returns to IDLE, drops gnt, and updates last_owner.
- Outside DATA, r_wready and d_rvalid are 0. A stray m_rvalid or m_wready is ignored.
- Minimum one IDLE cycle between bursts. Request-to-grant latency is 1 cycle.
- wait_cnt: increments while r_req && !r_gnt, saturating at MAX_WAIT; clears when the renderer is granted or r_req falls.
- A requester's req is held until its gnt rises; dropping req before grant withdraws the request.
- RST mid-burst: immediately back to IDLE with all outputs at reset values. The SDRAM controller shares RST, so no partial-burst recovery is needed.

Optional Feature:
- FBARB_STATS_EN defined adds outputs stat_d_bursts[31:0], stat_r_bursts[31:0], stat_urgent_stall[31:0].
  - Burst counters increment on each completed burst per owner.
  - stall counts cycles with d_urgent && d_req && !d_gnt.
  - All three wrap at 2^32, are cleared by RST, and are plain registers.
- Undefined: these ports and registers are absent; arbitration is identical.

Decomposition:
- Package fb_mem_pkg: state enum (IDLE/CMD/DATA), owner enum (OWN_DISP/OWN_REND), default ADDR_W/DATA_W/BURST constants shared with the SDRAM controller and the scanout/render blocks.
- Sub-module fb_arb_pick: combinational winner selection from req/urgent/starve/last_owner. Everything else stays in the top.

Test Plan:
- Only d_req, addr 0x000100; controller ready immediately, 8 m_rvalid beats -> one m_cmd_valid with we=0, addr 0x000100; exactly 8 d_rvalid; d_gnt falls after beat 8.
- Both req, no urgency, back-to-back -> grants alternate D,R,D,R; each write burst gives exactly 8 r_wready pulses matching m_wready.
- d_urgent held, r_req held, MAX_WAIT=64 -> display wins until wait_cnt hits 64; the next grant goes to the renderer, then display resumes.
- m_cmd_ready held low for 5 cycles -> m_cmd_valid, addr and we stable for all 5; no data beats forwarded.
- RST asserted after beat 3 of a write -> the next cycle has all gnt/valid outputs 0 and state IDLE; the next burst completes a full 8 beats.
- With FBARB_STATS_EN: 3 display and 2 renderer bursts -> stat_d_bursts = 3, stat_r_bursts = 2.

Source files
------------

// File: rtl/fb_mem_pkg.sv
// Shared framebuffer memory types: arbiter FSM states, port owners and default bus geometry
// used by the SDRAM controller, scanout and renderer blocks.
package fb_mem_pkg;

  localparam int FB_ADDR_W   = 22;
  localparam int FB_DATA_W   = 32;
  localparam int FB_BURST    = 8;
  localparam int FB_MAX_WAIT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_REND = 1'b1
  } owner_e;

  // Round-robin: whoever did not own the previous burst goes next.
  function automatic owner_e rr_next(input owner_e last);
    return (last == OWN_REND) ? OWN_DISP : OWN_REND;
  endfunction

endpackage

// File: rtl/fb_arb_pick.sv
// Combinational burst winner: starving renderer, then urgent display, then round-robin, then lone requester.
// Zero latency; no backpressure of its own (only consulted while the arbiter is idle).
module fb_arb_pick
  import fb_mem_pkg::*;
(
  input  logic   d_req,
  input  logic   d_urgent,
  input  logic   r_req,
  input  logic   r_starve,
  input  owner_e last_owner,
  output logic   pick_vld,
  output owner_e pick_owner
);

  always_comb begin
    pick_vld   = d_req | r_req;
    pick_owner = OWN_DISP;
    if (r_req && r_starve) begin
      pick_owner = OWN_REND;
    end else if (d_req && d_urgent) begin
      pick_owner = OWN_DISP;
    end else if (d_req && r_req) begin
      pick_owner = rr_next(last_owner);
    end else if (r_req) begin
      pick_owner = OWN_REND;
    end
  end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Shares the SDRAM command/data port between LCD scanout (read bursts) and the renderer (write bursts);
// grant 1 cycle after req, data beats stall on m_wready/m_rvalid. FBARB_STATS_EN adds burst/stall counters.
module fb_mem_arbiter
  import fb_mem_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DATA_W   = FB_DATA_W,
  parameter int BURST    = FB_BURST,
  parameter int MAX_WAIT = FB_MAX_WAIT
) (
  input  logic              PLD_CLOCKINPUT,
  input  logic              RST,
  input  logic              d_req,
  input  logic              d_urgent,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_wdata,
  output logic              r_wready,
  output logic              r_gnt,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic              m_cmd_we,
  output logic [ADDR_W-1:0] m_cmd_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_wready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
`ifdef FBARB_STATS_EN
  ,
  output logic [31:0]       stat_d_bursts,
  output logic [31:0]       stat_r_bursts,
  output logic [31:0]       stat_urgent_stall
`endif
);

  localparam int BEAT_W = $clog2(BURST);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  arb_state_e        state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  logic              d_gnt_q, d_gnt_d;
  logic              r_gnt_q, r_gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic   pick_vld;
  owner_e pick_owner;
  logic   starve;
  logic   in_data;
  logic   beat_hs;
  logic   last_beat;
  logic   grant_r;

  assign starve    = (wait_q == WAIT_W'(MAX_WAIT));
  assign in_data   = (state_q == DATA);
  assign beat_hs   = in_data && (we_q ? m_wready : m_rvalid);
  assign last_beat = (beat_q == BEAT_W'(BURST - 1));

  fb_arb_pick u_pick (
    .d_req      (d_req),
    .d_urgent   (d_urgent),
    .r_req      (r_req),
    .r_starve   (starve),
    .last_owner (last_owner_q),
    .pick_vld   (pick_vld),
    .pick_owner (pick_owner)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    d_gnt_d      = d_gnt_q;
    r_gnt_d      = r_gnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    grant_r      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = CMD;
          we_d    = (pick_owner == OWN_REND);
          addr_d  = (pick_owner == OWN_REND) ? r_addr : d_addr;
          d_gnt_d = (pick_owner == OWN_DISP);
          r_gnt_d = (pick_owner == OWN_REND);
          grant_r = (pick_owner == OWN_REND);
        end
      end
      CMD: begin
        if (m_cmd_ready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (beat_hs) begin
          if (last_beat) begin
            state_d      = IDLE;
            d_gnt_d      = 1'b0;
            r_gnt_d      = 1'b0;
            beat_d       = '0;
            last_owner_d = we_q ? OWN_REND : OWN_DISP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Renderer patience: counts only while it asks and is not being served.
  always_comb begin
    wait_d = wait_q;
    if (!r_req || r_gnt_q || grant_r) begin
      wait_d = '0;
    end else if (!starve) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge PLD_CLOCKINPUT) begin
    if (RST) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_REND;
      d_gnt_q      <= 1'b0;
      r_gnt_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      beat_q       <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      d_gnt_q      <= d_gnt_d;
      r_gnt_q      <= r_gnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
    end
  end

  assign d_gnt       = d_gnt_q;
  assign r_gnt       = r_gnt_q;
  assign m_cmd_valid = (state_q == CMD);
  assign m_cmd_we    = we_q;
  assign m_cmd_addr  = addr_q;
  // Data paths are only open to the owner during DATA; stray controller strobes go nowhere.
  assign r_wready    = in_data && we_q && m_wready;
  assign d_rvalid    = in_data && !we_q && m_rvalid;
  assign m_wdata     = (in_data && we_q) ? r_wdata : '0;
  assign d_rdata     = (in_data && !we_q) ? m_rdata : '0;

`ifdef FBARB_STATS_EN
  logic [31:0] stat_d_bursts_q, stat_d_bursts_d;
  logic [31:0] stat_r_bursts_q, stat_r_bursts_d;
  logic [31:0] stat_urgent_stall_q, stat_urgent_stall_d;

  always_comb begin
    stat_d_bursts_d     = stat_d_bursts_q;
    stat_r_bursts_d     = stat_r_bursts_q;
    stat_urgent_stall_d = stat_urgent_stall_q;
    if (beat_hs && last_beat) begin
      if (we_q) begin
        stat_r_bursts_d = stat_r_bursts_q + 32'd1;
      end else begin
        stat_d_bursts_d = stat_d_bursts_q + 32'd1;
      end
    end
    if (d_urgent && d_req && !d_gnt_q) begin
      stat_urgent_stall_d = stat_urgent_stall_q + 32'd1;
    end
  end

  always_ff @(posedge PLD_CLOCKINPUT) begin
    if (RST) begin
      stat_d_bursts_q     <= '0;
      stat_r_bursts_q     <= '0;
      stat_urgent_stall_q <= '0;
    end else begin
      stat_d_bursts_q     <= stat_d_bursts_d;
      stat_r_bursts_q     <= stat_r_bursts_d;
      stat_urgent_stall_q <= stat_urgent_stall_d;
    end
  end

  assign stat_d_bursts     = stat_d_bursts_q;
  assign stat_r_bursts     = stat_r_bursts_q;
  assign stat_urgent_stall = stat_urgent_stall_q;
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Randomised bench for fb_mem_arbiter against a cycle-level reference of the arbitration and burst rules.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
module tb_fb_mem_arbiter;
  import fb_mem_pkg::*;

  localparam int AW = FB_ADDR_W;
  localparam int DW = FB_DATA_W;
  localparam int BL = FB_BURST;
  localparam int MW = FB_MAX_WAIT;

  logic          clk = 1'b0;
  logic          RST;
  logic          d_req, d_urgent, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_rdata;
  logic          r_req, r_wready, r_gnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          m_cmd_valid, m_cmd_ready, m_cmd_we;
  logic [AW-1:0] m_cmd_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_wready, m_rvalid;
`ifdef FBARB_STATS_EN
  logic [31:0]   stat_d_bursts, stat_r_bursts, stat_urgent_stall;
`endif

  always #5 clk = ~clk;

  fb_mem_arbiter dut (
    .PLD_CLOCKINPUT (clk),
    .RST            (RST),
    .d_req          (d_req),
    .d_urgent       (d_urgent),
    .d_addr         (d_addr),
    .d_gnt          (d_gnt),
    .d_rvalid       (d_rvalid),
    .d_rdata        (d_rdata),
    .r_req          (r_req),
    .r_addr         (r_addr),
    .r_wdata        (r_wdata),
    .r_wready       (r_wready),
    .r_gnt          (r_gnt),
    .m_cmd_valid    (m_cmd_valid),
    .m_cmd_ready    (m_cmd_ready),
    .m_cmd_we       (m_cmd_we),
    .m_cmd_addr     (m_cmd_addr),
    .m_wdata        (m_wdata),
    .m_wready       (m_wready),
    .m_rvalid       (m_rvalid),
    .m_rdata        (m_rdata)
`ifdef FBARB_STATS_EN
    ,
    .stat_d_bursts     (stat_d_bursts),
    .stat_r_bursts     (stat_r_bursts),
    .stat_urgent_stall (stat_urgent_stall)
`endif
  );

  int n_chk;
  int n_fail;

  // Reference: phase 0 idle, 1 command, 2 data; owner 0 display, 1 renderer.
  int            md_ph, md_own, md_beats, md_wait, md_last;
  logic [AW-1:0] md_addr;
  logic          md_we;
  int unsigned   md_sd, md_sr, md_ss;

  // Stimulus knobs (percent per cycle, p_rst per mille).
  int p_dreq, p_rreq, p_urg, p_cmd, p_wrdy, p_rvld, p_rst;
  bit fix_addr;
  int rst_at_wbeat;
  bit rst_fired;

  // Independent observation of DUT behaviour.
  int cnt_cmd, cnt_drv, cnt_rwr, burst_cnt;
  logic [1:0] prev_gnt;
  bit last_rst;
  int grant_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic model_reset();
    md_ph = 0; md_own = 0; md_beats = 0; md_wait = 0; md_last = 1;
    md_addr = '0; md_we = 1'b0;
    md_sd = 0; md_sr = 0; md_ss = 0;
  endtask

  task automatic set_knobs(input int dq, input int rq, input int ur, input int cr, input int wr, input int rv);
    p_dreq = dq; p_rreq = rq; p_urg = ur; p_cmd = cr; p_wrdy = wr; p_rvld = rv;
  endtask

  task automatic clear_obs();
    cnt_cmd = 0; cnt_drv = 0; cnt_rwr = 0;
    grant_q.delete();
  endtask

  task automatic check_outputs();
    logic exp_dg, exp_rg, exp_rw, exp_dv;
    exp_dg = (md_ph != 0) && (md_own == 0);
    exp_rg = (md_ph != 0) && (md_own == 1);
    exp_rw = (md_ph == 2) && (md_own == 1) && m_wready;
    exp_dv = (md_ph == 2) && (md_own == 0) && m_rvalid;
    if (last_rst) check_eq("post_rst_idle", {d_gnt, r_gnt, m_cmd_valid, r_wready, d_rvalid}, 5'b0);
    check_eq("d_gnt", d_gnt, exp_dg);
    check_eq("r_gnt", r_gnt, exp_rg);
    check_eq("m_cmd_valid", m_cmd_valid, md_ph == 1);
    if (md_ph == 1) begin
      check_eq("m_cmd_addr", m_cmd_addr, md_addr);
      check_eq("m_cmd_we", m_cmd_we, md_we);
    end
    check_eq("r_wready", r_wready, exp_rw);
    check_eq("d_rvalid", d_rvalid, exp_dv);
    if (exp_dv) check_eq("d_rdata", d_rdata, m_rdata);
    if (md_ph == 2 && md_own == 1) check_eq("m_wdata", m_wdata, r_wdata);
`ifdef FBARB_STATS_EN
    check_eq("stat_d_bursts", stat_d_bursts, md_sd);
    check_eq("stat_r_bursts", stat_r_bursts, md_sr);
    check_eq("stat_urgent_stall", stat_urgent_stall, md_ss);
`endif
  endtask

  task automatic observe();
    logic [1:0] cur;
    if (m_cmd_valid) cnt_cmd++;
    if (d_rvalid) cnt_drv++;
    if (r_wready) cnt_rwr++;
    if (d_rvalid || r_wready) burst_cnt++;
    cur = {r_gnt, d_gnt};
    if (prev_gnt == 2'b00 && cur != 2'b00) grant_q.push_back(r_gnt ? 1 : 0);
    if (prev_gnt != 2'b00 && cur == 2'b00) begin
      check_eq("burst_len", burst_cnt, BL);
      burst_cnt = 0;
    end
    prev_gnt = cur;
    if (RST) begin
      prev_gnt  = 2'b00;
      burst_cnt = 0;
    end
  endtask

  task automatic model_step();
    bit cur_dg, cur_rg, granted_r, hs;
    int w;
    cur_dg = (md_ph != 0) && (md_own == 0);
    cur_rg = (md_ph != 0) && (md_own == 1);
    granted_r = 1'b0;
    if (RST) begin
      model_reset();
    end else begin
      if (d_urgent && d_req && !cur_dg) md_ss++;
      case (md_ph)
        0: begin
          w = -1;
          if (r_req && md_wait == MW) w = 1;
          else if (d_req && d_urgent) w = 0;
          else if (d_req && r_req) w = (md_last == 1) ? 0 : 1;
          else if (d_req) w = 0;
          else if (r_req) w = 1;
          if (w >= 0) begin
            md_ph = 1; md_own = w; md_we = (w == 1);
            md_addr = (w == 1) ? r_addr : d_addr;
            granted_r = (w == 1);
          end
        end
        1: if (m_cmd_ready) begin md_ph = 2; md_beats = 0; end
        default: begin
          hs = (md_own == 1) ? m_wready : m_rvalid;
          if (hs) begin
            md_beats++;
            if (md_beats == BL) begin
              md_ph = 0;
              md_last = md_own;
              if (md_own == 1) md_sr++; else md_sd++;
            end
          end
        end
      endcase
      if (!r_req || cur_rg || granted_r) md_wait = 0;
      else if (md_wait < MW) md_wait++;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      RST = 1'b0;
      if (rst_at_wbeat >= 0 && md_ph == 2 && md_own == 1 && burst_cnt == rst_at_wbeat) begin
        RST = 1'b1; rst_fired = 1'b1; rst_at_wbeat = -1;
      end
      if (p_rst > 0 && $urandom_range(999, 0) < p_rst) RST = 1'b1;
      d_req       = (md_ph != 0 && md_own == 0) ? 1'b0 : pct(p_dreq);
      r_req       = (md_ph != 0 && md_own == 1) ? 1'b0 : pct(p_rreq);
      d_urgent    = pct(p_urg);
      d_addr      = fix_addr ? AW'(32'h100) : AW'($urandom());
      r_addr      = AW'($urandom());
      r_wdata     = $urandom();
      m_rdata     = $urandom();
      m_cmd_ready = pct(p_cmd);
      m_wready    = pct(p_wrdy);
      m_rvalid    = pct(p_rvld);
      #1;
      check_outputs();
      observe();
      model_step();
      last_rst = RST;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    set_knobs(0, 0, 0, 100, 100, 100);
    run_cycles(16);
  endtask

  initial begin
    int first_r;
    bit d_after;
    n_chk = 0; n_fail = 0;
    RST = 1'b1;
    d_req = 0; d_urgent = 0; d_addr = '0; r_req = 0; r_addr = '0; r_wdata = '0;
    m_cmd_ready = 0; m_wready = 0; m_rvalid = 0; m_rdata = '0;
    set_knobs(0, 0, 0, 0, 0, 0);
    p_rst = 0; fix_addr = 0; rst_at_wbeat = -1; rst_fired = 0;
    burst_cnt = 0; prev_gnt = 2'b00; last_rst = 0;
    clear_obs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_d_gnt", d_gnt, 1'b0);
    check_eq("rst_r_gnt", r_gnt, 1'b0);
    check_eq("rst_cmd_valid", m_cmd_valid, 1'b0);
    check_eq("rst_cmd_we", m_cmd_we, 1'b0);
    check_eq("rst_cmd_addr", m_cmd_addr, '0);
    check_eq("rst_r_wready", r_wready, 1'b0);
    check_eq("rst_d_rvalid", d_rvalid, 1'b0);

    // Both requesting, no urgency: grants alternate starting with display.
    clear_obs();
    set_knobs(100, 100, 0, 100, 70, 70);
    run_cycles(120);
    check_eq("alt_count", grant_q.size() >= 4, 1'b1);
    if (grant_q.size() > 0) check_eq("alt_first_disp", grant_q[0], 0);
    for (int i = 1; i < grant_q.size(); i++) check_eq("alt_order", grant_q[i] != grant_q[i-1], 1'b1);
    drain();

    // Single display burst at 0x000100.
    clear_obs();
    fix_addr = 1;
    set_knobs(100, 0, 0, 100, 0, 100);
    run_cycles(1);
    p_dreq = 0;
    run_cycles(15);
    fix_addr = 0;
    check_eq("disp_cmd_cycles", cnt_cmd, 1);
    check_eq("disp_rvalid_beats", cnt_drv, BL);
    check_eq("disp_gnt_done", d_gnt, 1'b0);

    // Urgent display vs held renderer: renderer breaks through once it has waited MAX_WAIT.
    drain();
    clear_obs();
    set_knobs(100, 100, 100, 100, 100, 100);
    run_cycles(260);
    first_r = -1;
    d_after = 0;
    for (int i = 0; i < grant_q.size(); i++) begin
      if (grant_q[i] == 1 && first_r < 0) first_r = i;
      else if (grant_q[i] == 0 && first_r >= 0) d_after = 1;
    end
    check_eq("starve_rend_granted", first_r > 0, 1'b1);
    check_eq("starve_disp_resumes", d_after, 1'b1);
    drain();

    // Controller stalls the command for 5 cycles while stray read strobes fly.
    clear_obs();
    set_knobs(100, 0, 0, 0, 0, 100);
    run_cycles(1);
    p_dreq = 0;
    run_cycles(5);
    check_eq("stall_cmd_cycles", cnt_cmd, 5);
    check_eq("stall_no_beats", cnt_drv, 0);
    p_cmd = 100;
    run_cycles(14);

    // Reset after the third write beat, then a clean full burst.
    drain();
    clear_obs();
    set_knobs(0, 100, 0, 100, 100, 0);
    run_cycles(1);
    p_rreq = 0;
    rst_at_wbeat = 3;
    run_cycles(10);
    check_eq("rst_mid_fired", rst_fired, 1'b1);
    rst_at_wbeat = -1;
    cnt_rwr = 0;
    p_rreq = 100;
    run_cycles(1);
    p_rreq = 0;
    run_cycles(14);
    check_eq("rst_next_burst_beats", cnt_rwr, BL);

    // Random mix with occasional resets.
    p_rst = 2;
    for (int k = 0; k < 15; k++) begin
      set_knobs($urandom_range(100, 10), $urandom_range(100, 10), $urandom_range(60, 0),
                $urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(100, 20));
      run_cycles(200);
    end
    p_rst = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
